// File: rtl/ir_pkg.sv
// Shared definitions for the serial IR frame decoder: FSM states, error codes
// and the default valid-key map for 8-bit keys.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_STOP,
        S_CHECK
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FRAME = 2'b01;
    localparam logic [1:0] ERR_CMPL  = 2'b10;
    localparam logic [1:0] ERR_KEY   = 2'b11;

    // Bit k set means key k is accepted.
    localparam logic [255:0] DEF_VALID_MAP = 256'hCDDF93FF;

endpackage

// File: rtl/ir_shift_reg.sv
// MSB-first serial-in shift register that holds the decoder payload
// (address, inverted address, data, inverted data).
module ir_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/ir_frame_decoder.sv
// Serial IR frame decoder: deframes start/addr/~addr/data/~data/stop, checks the
// fields and pulses ready or err. Define ADDR_FILTER_EN to accept only MY_ADDR.
module ir_frame_decoder
    import ir_pkg::*;
#(
    parameter int                   ADDR_W    = 8,
    parameter int                   DATA_W    = 8,
    parameter int                   START_LEN = 1,
    parameter logic [2**DATA_W-1:0] VALID_MAP = (2**DATA_W)'(DEF_VALID_MAP),
    parameter logic [ADDR_W-1:0]    MY_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial,
    output logic [DATA_W-1:0] tecla,
    output logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int PAY_W = 2*ADDR_W + 2*DATA_W;
    localparam int CNT_W = $clog2(PAY_W + 1);
    localparam int SL_W  = $clog2(START_LEN + 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(PAY_W - 1);
    localparam logic [SL_W-1:0]  START_LAST = SL_W'(START_LEN - 1);

`ifdef ADDR_FILTER_EN
    localparam bit ADDR_FILTER = 1'b1;
`else
    localparam bit ADDR_FILTER = 1'b0;
`endif

    state_t            state, next_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SL_W-1:0]   low_cnt;
    logic [PAY_W-1:0]  payload;
    logic              shift_en;

    logic [ADDR_W-1:0] frame_addr, addr_inv;
    logic [DATA_W-1:0] frame_data, data_inv;
    logic              cmpl_ok, key_ok, addr_ok;
    logic [1:0]        res_code;

    ir_shift_reg #(.W(PAY_W)) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .din (serial),
        .q   (payload)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        case (state)
            S_IDLE:  if (!serial) next_state = (START_LEN == 1) ? S_SHIFT : S_START;
            S_START: begin
                if (serial)                    next_state = S_IDLE;
                else if (low_cnt == START_LAST) next_state = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == BIT_LAST) next_state = S_STOP;
            end
            S_STOP:  next_state = S_CHECK;
            S_CHECK: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // low_cnt counts start lows already seen; bit_cnt counts payload bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            low_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    low_cnt <= SL_W'(1);
                end
                S_START: low_cnt <= low_cnt + 1'b1;
                S_SHIFT: bit_cnt <= bit_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign frame_addr = payload[PAY_W-1 -: ADDR_W];
    assign addr_inv   = payload[PAY_W-ADDR_W-1 -: ADDR_W];
    assign frame_data = payload[2*DATA_W-1 -: DATA_W];
    assign data_inv   = payload[DATA_W-1:0];

    assign cmpl_ok = (&(frame_addr ^ addr_inv)) && (&(frame_data ^ data_inv));
    assign key_ok  = VALID_MAP[frame_data];
    assign addr_ok = !ADDR_FILTER || (frame_addr == MY_ADDR);

    // While in STOP, serial carries the stop bit; priority framing > complement > key.
    always_comb begin
        res_code = ERR_NONE;
        if (!serial)                res_code = ERR_FRAME;
        else if (!cmpl_ok)          res_code = ERR_CMPL;
        else if (!key_ok || !addr_ok) res_code = ERR_KEY;
    end

    // Results are registered on the stop-bit edge so they are visible during CHECK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tecla    <= '0;
            addr     <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            ready    <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            if (state == S_STOP) begin
                if (res_code == ERR_NONE) begin
                    ready <= 1'b1;
                    tecla <= frame_data;
                    addr  <= frame_addr;
                end else begin
                    err      <= 1'b1;
                    err_code <= res_code;
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Self-checking bench for ir_frame_decoder: a frame-level outcome model plus a
// per-cycle compare process, on a START_LEN=1 and a START_LEN=2 instance.
module tb_ir_frame_decoder;

`ifdef ADDR_FILTER_EN
    localparam logic [7:0] MYA  = 8'h40;
    localparam bit         FILT = 1'b1;
`else
    localparam logic [7:0] MYA  = 8'h00;
    localparam bit         FILT = 1'b0;
`endif
    localparam logic [255:0] VMAP = 256'hCDDF93FF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] ser = 2'b11;
    logic [1:0] rdy, er;
    logic [1:0] ec [2];
    logic [7:0] tk [2];
    logic [7:0] ad [2];

    always #5 clk = ~clk;

    ir_frame_decoder #(.ADDR_W(8), .DATA_W(8), .START_LEN(1), .VALID_MAP(VMAP), .MY_ADDR(MYA)) u_dut0 (
        .clk(clk), .rst(rst), .serial(ser[0]), .tecla(tk[0]), .addr(ad[0]),
        .ready(rdy[0]), .err(er[0]), .err_code(ec[0])
    );

    ir_frame_decoder #(.ADDR_W(8), .DATA_W(8), .START_LEN(2), .VALID_MAP(VMAP), .MY_ADDR(MYA)) u_dut1 (
        .clk(clk), .rst(rst), .serial(ser[1]), .tecla(tk[1]), .addr(ad[1]),
        .ready(rdy[1]), .err(er[1]), .err_code(ec[1])
    );

    typedef struct {
        int         unit;
        int         cyc_i;
        logic [1:0] code;
        logic [7:0] key;
        logic [7:0] a;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] held_key  [2] = '{default: 8'h00};
    logic [7:0] held_addr [2] = '{default: 8'h00};
    logic [1:0] last_code [2] = '{default: 2'b00};
    int         last_ready_cyc [2] = '{default: 0};
    int         start_cyc [2] = '{default: 0};
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outcome of one frame from the decoding rules; 00 means accepted.
    function automatic logic [1:0] model_code(input logic [7:0] a, input logic [7:0] ai,
                                              input logic [7:0] d, input logic [7:0] di,
                                              input logic stop);
        if (!stop) return 2'b01;
        if ((9'(a) + 9'(ai)) != 9'd255 || (9'(d) + 9'(di)) != 9'd255) return 2'b10;
        if (!VMAP[d]) return 2'b11;
        if (FILT && a != MYA) return 2'b11;
        return 2'b00;
    endfunction

    // Compare process: runs just after every rising edge.
    logic       exp_r, exp_e;
    logic [1:0] exp_c;
    int         idx;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int u = 0; u < 2; u++) begin
                exp_r = 1'b0;
                exp_e = 1'b0;
                exp_c = 2'b00;
                idx   = -1;
                foreach (exp_q[i]) if (exp_q[i].unit == u && exp_q[i].cyc_i == cyc) idx = i;
                if (idx >= 0) begin
                    if (exp_q[idx].code == 2'b00) begin
                        exp_r        = 1'b1;
                        held_key[u]  = exp_q[idx].key;
                        held_addr[u] = exp_q[idx].a;
                    end else begin
                        exp_e = 1'b1;
                        exp_c = exp_q[idx].code;
                    end
                    exp_q.delete(idx);
                end
                check($sformatf("u%0d ready", u), 32'(rdy[u]), 32'(exp_r));
                check($sformatf("u%0d err", u), 32'(er[u]), 32'(exp_e));
                if (exp_e) check($sformatf("u%0d err_code", u), 32'(ec[u]), 32'(exp_c));
                check($sformatf("u%0d tecla", u), 32'(tk[u]), 32'(held_key[u]));
                check($sformatf("u%0d addr", u), 32'(ad[u]), 32'(held_addr[u]));
                if (rdy[u]) last_ready_cyc[u] = cyc;
                if (er[u])  last_code[u] = ec[u];
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ser = 2'b11;
        end
    endtask

    // Drives one frame on unit u; cut >= 0 stops after that many payload bits.
    task automatic send_frame(input int u, input logic [7:0] a, input logic [7:0] ai,
                              input logic [7:0] d, input logic [7:0] di,
                              input logic stop, input int cut);
        int          sl = (u == 0) ? 1 : 2;
        logic [32:0] v;
        v = {a, ai, d, di, stop};
        for (int i = 0; i < sl; i++) begin
            @(negedge clk);
            ser[u] = 1'b0;
            if (i == 0) start_cyc[u] = cyc + 1;
        end
        for (int i = 32; i >= 0; i--) begin
            if (cut >= 0 && (32 - i) == cut) return;
            @(negedge clk);
            ser[u] = v[i];
            if (i == 0) exp_q.push_back('{unit: u, cyc_i: cyc + 1,
                                          code: model_code(a, ai, d, di, stop), key: d, a: a});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset tecla", 32'(tk[0]), 32'h00);
        check("reset addr", 32'(ad[0]), 32'h00);
        check("reset ready", 32'(rdy[0]), 32'h0);
        rst = 1'b1;
        idle(3);

        // Valid frame, then complement and key failures.
        send_frame(0, 8'h00, 8'hFF, 8'h09, 8'hF6, 1'b1, -1); idle(3);
`ifndef ADDR_FILTER_EN
        check("t1 tecla", 32'(tk[0]), 32'h09);
        check("t1 addr", 32'(ad[0]), 32'h00);
        check("t1 latency", 32'(last_ready_cyc[0] - start_cyc[0]), 32'd33);
`endif
        send_frame(0, 8'h00, 8'hFF, 8'h09, 8'hF7, 1'b1, -1); idle(3);
`ifndef ADDR_FILTER_EN
        check("t2 code", 32'(last_code[0]), 32'h2);
        check("t2 tecla held", 32'(tk[0]), 32'h09);
`endif
        send_frame(0, 8'h00, 8'hFE, 8'h09, 8'hF6, 1'b1, -1); idle(3);
        send_frame(0, 8'h00, 8'hFF, 8'h0A, 8'hF5, 1'b1, -1); idle(1);
`ifndef ADDR_FILTER_EN
        check("t3 code", 32'(last_code[0]), 32'h3);
`endif
        send_frame(0, 8'h00, 8'hFF, 8'h1F, 8'hE0, 1'b1, -1); idle(3);
`ifndef ADDR_FILTER_EN
        check("t3 tecla", 32'(tk[0]), 32'h1F);
`endif

        // Framing error outranks a bad complement; a low during CHECK is ignored.
        send_frame(0, 8'h00, 8'hFF, 8'h09, 8'hF6, 1'b0, -1); idle(3);
        check("t4 code", 32'(last_code[0]), 32'h1);
        send_frame(0, 8'h00, 8'h00, 8'h09, 8'hF7, 1'b0, -1); idle(3);
        send_frame(0, 8'h00, 8'hFF, 8'h16, 8'hE9, 1'b1, -1);
        @(negedge clk); ser[0] = 1'b0;
        idle(40);
        send_frame(0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, -1); idle(1);
        send_frame(0, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1, -1); idle(3);

        // One-sample glitch must not start a frame when two lows are required.
        @(negedge clk); ser[1] = 1'b0;
        idle(40);
        send_frame(1, 8'h00, 8'hFF, 8'h1F, 8'hE0, 1'b1, -1); idle(3);
`ifndef ADDR_FILTER_EN
        check("t4 u1 tecla", 32'(tk[1]), 32'h1F);
`endif

        // Reset part-way through the payload.
        send_frame(0, 8'h00, 8'hFF, 8'h09, 8'hF6, 1'b1, 20);
        @(negedge clk);
        rst = 1'b0;
        ser = 2'b11;
        exp_q.delete();
        held_key  = '{default: 8'h00};
        held_addr = '{default: 8'h00};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(3);
        check("t5 tecla cleared", 32'(tk[0]), 32'h00);
        send_frame(0, 8'h00, 8'hFF, 8'h1F, 8'hE0, 1'b1, -1); idle(3);
`ifndef ADDR_FILTER_EN
        check("t5 tecla", 32'(tk[0]), 32'h1F);
`endif

`ifdef ADDR_FILTER_EN
        send_frame(0, 8'h00, 8'hFF, 8'h09, 8'hF6, 1'b1, -1); idle(3);
        check("t6 code", 32'(last_code[0]), 32'h3);
        send_frame(0, 8'h40, 8'hBF, 8'h09, 8'hF6, 1'b1, -1); idle(3);
        check("t6 tecla", 32'(tk[0]), 32'h09);
        check("t6 addr", 32'(ad[0]), 32'h40);
`endif

        idle(5);
        check("pending expectations", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
